led_mode_ctrl: RTL

//  Upstream control stage for the four-rate LED blinker (10/5/2/1 Hz on LED_1..LED_4).
//  - Synchronises and debounces one raw push switch.
//  - Counts presses (registered on release) and steps a 4-state display-mode FSM.
//  - Drives a per-LED enable mask; the top level ANDs it with the blinker outputs.

---
 rtl/led_mode_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl: synchronises and debounces the push switch, counts releases and
// steps the LED display mode (ALL -> SLOW -> FAST -> OFF), driving a per-LED enable mask.
// Optional feature macro: LED_MODE_LONGPRESS_EN - a release after a hold of
// g_LONG_COUNT debounced cycles returns the mode to ALL instead of advancing it.
module led_mode_ctrl #(
    parameter int unsigned g_DEBOUNCE_LIMIT = 250000,
    parameter int unsigned g_LONG_COUNT     = 25000000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Switch_1,
    output logic [3:0] o_LED_En,
    output logic [1:0] o_Mode,
    output logic       o_Mode_Chg
);

    localparam int unsigned CNT_W = 32;
    localparam int unsigned LED_W = 4;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(g_DEBOUNCE_LIMIT - 1);

    localparam logic [LED_W-1:0] MASK_ALL  = 4'b1111;
    localparam logic [LED_W-1:0] MASK_SLOW = 4'b1100;
    localparam logic [LED_W-1:0] MASK_FAST = 4'b0011;
    localparam logic [LED_W-1:0] MASK_OFF  = 4'b0000;

    typedef enum logic [1:0] {
        MODE_ALL  = 2'd0,
        MODE_SLOW = 2'd1,
        MODE_FAST = 2'd2,
        MODE_OFF  = 2'd3
    } mode_t;

    logic             r_sync_meta;
    logic             r_sync;
    logic             r_deb;
    logic             r_deb_d;
    logic [CNT_W-1:0] r_deb_cnt;

    mode_t            r_mode;
    mode_t            mode_nxt_c;
    logic [LED_W-1:0] en_nxt_c;
    logic             chg_nxt_c;

    logic             release_c;
    logic             long_c;

    // Two-flop synchroniser, debounce counter and debounced-level history
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_sync_meta <= 1'b0;
            r_sync      <= 1'b0;
            r_deb       <= 1'b0;
            r_deb_d     <= 1'b0;
            r_deb_cnt   <= '0;
        end else begin
            r_sync_meta <= i_Switch_1;
            r_sync      <= r_sync_meta;
            r_deb_d     <= r_deb;
            if (r_sync == r_deb) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == DEB_LAST) begin
                r_deb     <= r_sync;
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + CNT_W'(1);
            end
        end
    end

    // A press is registered on the debounced release edge
    assign release_c = r_deb_d & ~r_deb;

`ifdef LED_MODE_LONGPRESS_EN
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(g_LONG_COUNT);

    logic [CNT_W-1:0] r_hold_cnt;

    // Saturating hold timer; still holds the press length in the release cycle
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_hold_cnt <= '0;
        end else if (!r_deb) begin
            r_hold_cnt <= '0;
        end else if (r_hold_cnt < HOLD_MAX) begin
            r_hold_cnt <= r_hold_cnt + CNT_W'(1);
        end
    end

    assign long_c = (r_hold_cnt == HOLD_MAX);
`else
    // Long-press threshold has no effect in this build; fold it into a sink
    logic unused_long_cfg;
    assign unused_long_cfg = ^CNT_W'(g_LONG_COUNT);
    assign long_c          = 1'b0;
`endif

    // Mode state register with its registered mask and change pulse
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_mode     <= MODE_ALL;
            o_LED_En   <= MASK_ALL;
            o_Mode_Chg <= 1'b0;
        end else begin
            r_mode     <= mode_nxt_c;
            o_LED_En   <= en_nxt_c;
            o_Mode_Chg <= chg_nxt_c;
        end
    end

    // Next mode on release, mask decoded from the next mode so both update together
    always_comb begin
        mode_nxt_c = r_mode;
        chg_nxt_c  = 1'b0;
        en_nxt_c   = MASK_ALL;

        if (release_c) begin
            chg_nxt_c = 1'b1;
            if (long_c) begin
                mode_nxt_c = MODE_ALL;
            end else begin
                case (r_mode)
                    MODE_ALL:  mode_nxt_c = MODE_SLOW;
                    MODE_SLOW: mode_nxt_c = MODE_FAST;
                    MODE_FAST: mode_nxt_c = MODE_OFF;
                    default:   mode_nxt_c = MODE_ALL;
                endcase
            end
        end

        case (mode_nxt_c)
            MODE_ALL:  en_nxt_c = MASK_ALL;
            MODE_SLOW: en_nxt_c = MASK_SLOW;
            MODE_FAST: en_nxt_c = MASK_FAST;
            default:   en_nxt_c = MASK_OFF;
        endcase
    end

    assign o_Mode = r_mode;

endmodule
